// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback always wins, and MDU results are
// buffered and drained into idle port cycles, with starvation relief and a RAW hazard query.
module rf_write_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wb_we,
  input  logic [4:0]               wb_waddr,
  input  logic [31:0]              wb_wdata,
  input  logic                     mdu_valid,
  output logic                     mdu_ready,
  input  logic [4:0]               mdu_waddr,
  input  logic [31:0]              mdu_wdata,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic                     stall_req,
  input  logic [4:0]               q_addr,
  output logic                     q_pending,
  output logic [$clog2(DEPTH):0]   pend_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = $clog2(MAX_WAIT + 1);

  logic [4:0]       addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    age_q, age_d;
  logic             stall_q, stall_d;
  logic             we_q, we_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic wb_busy_s, empty_s, full_s, head_vld_s, accept_s;
  logic pop_s, push_s, bypass_s, hit_s;

  // Arbitration, FIFO bookkeeping and starvation age for the next cycle.
  always_comb begin
    wb_busy_s  = wb_we && (wb_waddr != 5'd0);
    empty_s    = (cnt_q == CW'(0));
    full_s     = (cnt_q == CW'(DEPTH));
    head_vld_s = !empty_s && vld_q[rd_ptr_q];
    mdu_ready  = rst_n && !full_s;
    accept_s   = mdu_valid && mdu_ready;
    pop_s      = 1'b0;
    bypass_s   = 1'b0;
    we_d       = 1'b0;
    waddr_d    = 5'd0;
    wdata_d    = 32'd0;

    if (wb_busy_s) begin
      we_d    = 1'b1;
      waddr_d = wb_waddr;
      wdata_d = wb_wdata;
      // A superseded head leaves without needing the port.
      pop_s   = !empty_s && !head_vld_s;
    end else if (!empty_s) begin
      pop_s = 1'b1;
      if (head_vld_s) begin
        we_d    = 1'b1;
        waddr_d = addr_q[rd_ptr_q];
        wdata_d = data_q[rd_ptr_q];
      end else begin
        we_d = 1'b0;
      end
    end else if (accept_s && (mdu_waddr != 5'd0)) begin
      bypass_s = 1'b1;
      we_d     = 1'b1;
      waddr_d  = mdu_waddr;
      wdata_d  = mdu_wdata;
    end else begin
      we_d = 1'b0;
    end

    push_s = accept_s && (mdu_waddr != 5'd0) && !bypass_s;

    vld_d = vld_q;
    if (pop_s) begin
      vld_d[rd_ptr_q] = 1'b0;
    end else begin
      vld_d = vld_d;
    end
    if (wb_busy_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q[i] == wb_waddr) begin
          vld_d[i] = 1'b0;
        end else begin
          vld_d[i] = vld_d[i];
        end
      end
    end else begin
      vld_d = vld_d;
    end
    // Pushed entry is younger than a same-cycle pipeline write, so it stays valid.
    if (push_s) begin
      vld_d[wr_ptr_q] = 1'b1;
    end else begin
      vld_d = vld_d;
    end

    rd_ptr_d = pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    wr_ptr_d = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    cnt_d    = cnt_q + CW'(push_s) - CW'(pop_s);

    if (empty_s || pop_s) begin
      age_d = AW'(0);
    end else if (age_q < AW'(MAX_WAIT)) begin
      age_d = age_q + AW'(1);
    end else begin
      age_d = age_q;
    end
    stall_d = (age_d == AW'(MAX_WAIT));
  end

  // RAW hazard query against live buffered entries and the entry being accepted.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (addr_q[i] == q_addr)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
    if (accept_s && (mdu_waddr == q_addr)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = hit_s;
    end
    q_pending = rst_n && (q_addr != 5'd0) && hit_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      age_q    <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else begin
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      age_q    <= age_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      if (push_s) begin
        addr_q[wr_ptr_q] <= mdu_waddr;
        data_q[wr_ptr_q] <= mdu_wdata;
      end
    end
  end

  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign stall_req = stall_q;
  assign pend_cnt  = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_rf_write_arbiter;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst_n, wb_we, mdu_valid, mdu_ready, rf_we, stall_req, q_pending;
  logic [4:0]  wb_waddr, mdu_waddr, rf_waddr, q_addr;
  logic [31:0] wb_wdata, mdu_wdata, rf_wdata;
  logic [$clog2(DEPTH):0] pend_cnt;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .q_addr(q_addr), .q_pending(q_pending), .pend_cnt(pend_cnt)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          v;
  } ent_t;

  ent_t        mq[$];
  int          m_age;
  bit          m_stall, m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic bit m_ready();
    return rst_n && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_qpend();
    bit hit = 1'b0;
    if (!rst_n || q_addr == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].v && mq[i].a == q_addr) hit = 1'b1;
    if (mdu_valid && mq.size() < DEPTH && mdu_waddr == q_addr) hit = 1'b1;
    return hit;
  endfunction

  // Advance the reference model with the current inputs, then clock the DUT.
  task automatic cycle();
    bit busy, acc, popped, byp;
    int pre;
    ent_t h;
    if (!rst_n) begin
      mq.delete();
      m_age = 0; m_stall = 0; m_we = 0; m_waddr = 5'd0; m_wdata = 32'd0;
    end else begin
      busy = wb_we && wb_waddr != 5'd0;
      acc = mdu_valid && mq.size() < DEPTH;
      pre = mq.size();
      popped = 0; byp = 0;
      m_we = 0; m_waddr = 5'd0; m_wdata = 32'd0;
      if (busy) begin
        m_we = 1; m_waddr = wb_waddr; m_wdata = wb_wdata;
        if (pre > 0 && !mq[0].v) begin
          void'(mq.pop_front());
          popped = 1;
        end
      end else if (pre > 0) begin
        h = mq.pop_front();
        popped = 1;
        if (h.v) begin
          m_we = 1; m_waddr = h.a; m_wdata = h.d;
        end
      end else if (acc && mdu_waddr != 5'd0) begin
        byp = 1;
        m_we = 1; m_waddr = mdu_waddr; m_wdata = mdu_wdata;
      end
      if (busy) foreach (mq[i]) if (mq[i].a == wb_waddr) mq[i].v = 0;
      if (acc && mdu_waddr != 5'd0 && !byp) mq.push_back('{mdu_waddr, mdu_wdata, 1'b1});
      if (pre == 0 || popped) m_age = 0;
      else if (m_age < MAX_WAIT) m_age++;
      m_stall = (m_age == MAX_WAIT);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 0; wb_waddr = 5'd0; wb_wdata = 32'd0;
    mdu_valid = 0; mdu_waddr = 5'd0; mdu_wdata = 32'd0; q_addr = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0; wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'h77; mdu_valid = 1; mdu_waddr = 5'd4;
    repeat (3) begin
      #1;
      n_cmp++;
      if (mdu_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_comb: got %b want 0", mdu_ready); end
      cycle();
      n_cmp++;
      if ({rf_we, stall_req, mdu_ready} !== 3'b000 || pend_cnt !== '0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_state: got we=%b stall=%b rdy=%b cnt=%0d addr=%0d data=%0h want all 0",
                 rf_we, stall_req, mdu_ready, pend_cnt, rf_waddr, rf_wdata);
      end
    end
    rst_n = 1; idle();
    cycle();
    n_cmp++;
    if (mdu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", mdu_ready); end
  endtask

  task automatic test_bypass();
    idle();
    mdu_valid = 1; mdu_waddr = 5'd5; mdu_wdata = 32'h1234;
    cycle();
    idle();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234 || pend_cnt !== '0) begin
      n_bad++;
      $display("FAIL bypass: got we=%b addr=%0d data=%0h cnt=%0d want 1/5/1234/0", rf_we, rf_waddr, rf_wdata, pend_cnt);
    end
    cycle();
    n_cmp++;
    if (rf_we !== 1'b0) begin n_bad++; $display("FAIL bypass_after: got we=%b want 0", rf_we); end
  endtask

  task automatic test_priority_full();
    idle();
    wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'h300;
    mdu_valid = 1; mdu_waddr = 5'd7; mdu_wdata = 32'hA;
    cycle();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || pend_cnt !== 2'd1) begin
      n_bad++; $display("FAIL prio_first: got we=%b addr=%0d cnt=%0d want 1/3/1", rf_we, rf_waddr, pend_cnt);
    end
    mdu_waddr = 5'd8; mdu_wdata = 32'hB;
    cycle();
    n_cmp++;
    if (pend_cnt !== 2'd2 || mdu_ready !== 1'b0) begin
      n_bad++; $display("FAIL full: got cnt=%0d rdy=%b want 2/0", pend_cnt, mdu_ready);
    end
    mdu_waddr = 5'd10; mdu_wdata = 32'hC;
    cycle();
    n_cmp++;
    if (pend_cnt !== 2'd2 || rf_waddr !== 5'd3) begin
      n_bad++; $display("FAIL full_reject: got cnt=%0d addr=%0d want 2/3", pend_cnt, rf_waddr);
    end
    idle();
    cycle();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA) begin
      n_bad++; $display("FAIL drain_r7: got we=%b addr=%0d data=%0h want 1/7/a", rf_we, rf_waddr, rf_wdata);
    end
    cycle();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'hB || pend_cnt !== '0) begin
      n_bad++; $display("FAIL drain_r8: got we=%b addr=%0d data=%0h cnt=%0d want 1/8/b/0", rf_we, rf_waddr, rf_wdata, pend_cnt);
    end
    cycle();
    n_cmp++;
    if (rf_we !== 1'b0) begin n_bad++; $display("FAIL drain_done: got we=%b want 0", rf_we); end
  endtask

  task automatic test_starvation();
    int c, k;
    idle();
    wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'h3;
    mdu_valid = 1; mdu_waddr = 5'd20; mdu_wdata = 32'h2020;
    cycle();
    mdu_valid = 0;
    c = 1;
    while (stall_req !== 1'b1 && c < 20) begin
      cycle();
      c++;
    end
    n_cmp++;
    if (c != MAX_WAIT + 1) begin n_bad++; $display("FAIL stall_latency: got %0d cycles want %0d", c, MAX_WAIT + 1); end
    wb_we = 0;
    cycle();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd20 || rf_wdata !== 32'h2020) begin
      n_bad++; $display("FAIL stall_drain: got we=%b addr=%0d data=%0h want 1/20/2020", rf_we, rf_waddr, rf_wdata);
    end
    k = 0;
    while (stall_req !== 1'b0 && k < 2) begin
      cycle();
      k++;
    end
    n_cmp++;
    if (stall_req !== 1'b0) begin n_bad++; $display("FAIL stall_release: got %b want 0", stall_req); end
    idle();
    cycle();
  endtask

  task automatic test_supersede();
    idle();
    wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'h3;
    mdu_valid = 1; mdu_waddr = 5'd9; mdu_wdata = 32'h55;
    cycle();
    mdu_valid = 0; q_addr = 5'd9;
    #1;
    n_cmp++;
    if (q_pending !== 1'b1) begin n_bad++; $display("FAIL sup_pending: got %b want 1", q_pending); end
    wb_waddr = 5'd9; wb_wdata = 32'h66;
    cycle();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h66 || q_pending !== 1'b0 || pend_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL sup_write: got we=%b addr=%0d data=%0h qp=%b cnt=%0d want 1/9/66/0/1",
               rf_we, rf_waddr, rf_wdata, q_pending, pend_cnt);
    end
    wb_we = 0;
    cycle();
    n_cmp++;
    if (rf_we !== 1'b0 || pend_cnt !== '0 || q_pending !== 1'b0) begin
      n_bad++; $display("FAIL sup_silent_pop: got we=%b cnt=%0d qp=%b want 0/0/0", rf_we, pend_cnt, q_pending);
    end
    idle();
  endtask

  task automatic test_query_r0();
    idle();
    wb_we = 1; wb_waddr = 5'd3; wb_wdata = 32'h3;
    mdu_valid = 1; mdu_waddr = 5'd12; mdu_wdata = 32'h1212;
    cycle();
    mdu_valid = 0; q_addr = 5'd12;
    #1;
    n_cmp++;
    if (q_pending !== 1'b1) begin n_bad++; $display("FAIL query_hit: got %b want 1", q_pending); end
    q_addr = 5'd13;
    #1;
    n_cmp++;
    if (q_pending !== 1'b0) begin n_bad++; $display("FAIL query_miss: got %b want 0", q_pending); end
    mdu_valid = 1; mdu_waddr = 5'd0; mdu_wdata = 32'hDEAD;
    cycle();
    n_cmp++;
    if (pend_cnt !== 2'd1 || rf_waddr !== 5'd3) begin
      n_bad++; $display("FAIL r0_discard: got cnt=%0d addr=%0d want 1/3", pend_cnt, rf_waddr);
    end
    wb_we = 0; mdu_waddr = 5'd14; mdu_wdata = 32'h1414;
    cycle();
    n_cmp++;
    if (pend_cnt !== 2'd1 || rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h1212) begin
      n_bad++;
      $display("FAIL push_pop: got cnt=%0d we=%b addr=%0d data=%0h want 1/1/12/1212", pend_cnt, rf_we, rf_waddr, rf_wdata);
    end
    mdu_waddr = 5'd0;
    cycle();
    n_cmp++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd14 || rf_wdata !== 32'h1414 || pend_cnt !== '0) begin
      n_bad++; $display("FAIL push_pop_drain: got we=%b addr=%0d cnt=%0d want 1/14/0", rf_we, rf_waddr, pend_cnt);
    end
    cycle();
    n_cmp++;
    if (rf_we !== 1'b0 || pend_cnt !== '0) begin
      n_bad++; $display("FAIL r0_bypass: got we=%b cnt=%0d want 0/0", rf_we, pend_cnt);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      wb_we     = m_stall ? 1'b0 : ($urandom_range(0, 2) != 0);
      wb_waddr  = 5'($urandom_range(0, 7));
      wb_wdata  = $urandom;
      mdu_valid = $urandom_range(0, 1);
      mdu_waddr = 5'($urandom_range(0, 7));
      mdu_wdata = $urandom;
      q_addr    = 5'($urandom_range(0, 7));
      #1;
      n_cmp++;
      if (mdu_ready !== m_ready() || q_pending !== m_qpend()) begin
        n_bad++;
        $display("FAIL rnd_comb[%0d]: got rdy=%b qp=%b want %b/%b", n, mdu_ready, q_pending, m_ready(), m_qpend());
      end
      cycle();
      n_cmp++;
      if (rf_we !== m_we || (m_we && (rf_waddr !== m_waddr || rf_wdata !== m_wdata)) ||
          stall_req !== m_stall || pend_cnt !== ($clog2(DEPTH) + 1)'(mq.size())) begin
        n_bad++;
        $display("FAIL rnd_reg[%0d]: got we=%b a=%0d d=%0h st=%b cnt=%0d want %b/%0d/%0h/%b/%0d",
                 n, rf_we, rf_waddr, rf_wdata, stall_req, pend_cnt, m_we, m_waddr, m_wdata, m_stall, mq.size());
      end
    end
  endtask

  initial begin
    rst_n = 0;
    idle();
    test_reset();
    test_bypass();
    test_priority_full();
    test_starvation();
    test_supersede();
    test_query_r0();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
